uart_rx: RTL



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync_2ff.sv | 36 +++
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, the bit-period helper and
// the default data width, which the future uart_tx is expected to reuse.
// PARITY is only reachable when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  // Whole clock cycles per bit; the remainder is dropped.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level. The reset value is a
// parameter so an idle-high line (UART RX, BTN_N) comes out of reset idle.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset
//   d_i    asynchronous input
//   q_o    synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; meta_q may go metastable, sync_q is the resolved copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: synchronizes the raw RX pin, detects the start edge, samples
// each bit at mid-period (8N1, LSB first) and presents bytes through a
// one-entry valid/ready holding register.
// Optional build macro UART_RX_PARITY_EN: frame becomes 8E1 and parity_err_o
// is added.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   rxd_i        raw serial line, idle high, asynchronous
//   data_o       received byte, stable while valid_o is high
//   valid_o      byte available
//   ready_i      consumer takes data_o when valid_o & ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: byte dropped, holding register full
//   parity_err_o one-cycle pulse: even-parity check failed (macro only)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClkFreq   = 50_000_000,
  parameter int unsigned BaudRate  = 115200,
  parameter int unsigned DataWidth = UART_DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int unsigned ClksPerBit = clks_per_bit(ClkFreq, BaudRate);
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned IdxW       = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataWidth - 1);

  logic                 rxs_s;
  logic                 falling_s;
  logic                 drain_s;

  uart_rx_state_e       state_q;
  logic                 rxs_prev_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DataWidth-1:0] shift_q;
  logic [DataWidth-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_q;
  logic                 parity_err_q;

  // Even parity: data bits plus the parity bit must XOR to zero.
  function automatic logic parity_bad(input logic [DataWidth-1:0] data,
                                      input logic                 par);
    return (^data) ^ par;
  endfunction
`endif

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rxd_i),
    .q_o   (rxs_s)
  );

  // Only a 1->0 transition starts a frame, so a line stuck low cannot retrigger.
  assign falling_s = rxs_prev_q & ~rxs_s;
  assign drain_s   = valid_q & ready_i;

  // Receive FSM together with the registered output and handshake stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rxs_prev_q   <= 1'b1;
      cnt_q        <= {CntW{1'b0}};
      idx_q        <= {IdxW{1'b0}};
      shift_q      <= {DataWidth{1'b0}};
      data_q       <= {DataWidth{1'b0}};
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxs_prev_q  <= rxs_s;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // A load in the STOP branch below overrides this clear.
      if (drain_s) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (falling_s) begin
            state_q <= START;
            cnt_q   <= {CntW{1'b0}};
          end
        end

        START: begin
          // Re-check the line half a bit in; a high level was only a glitch.
          if (cnt_q == HalfLast) begin
            cnt_q   <= {CntW{1'b0}};
            idx_q   <= {IdxW{1'b0}};
            state_q <= rxs_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        DATA: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= {CntW{1'b0}};
            shift_q <= {rxs_s, shift_q[DataWidth-1:1]};
            if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BitLast) begin
            cnt_q    <= {CntW{1'b0}};
            parity_q <= rxs_s;
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif

        STOP: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= {CntW{1'b0}};
            state_q <= IDLE;
            // Priority: framing error, then parity error, then load/overrun.
            if (!rxs_s) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad(shift_q, parity_q)) begin
              parity_err_q <= 1'b1;
`endif
            end else if (!valid_q || drain_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= {CntW{1'b0}};
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
